regfile_wb_responder: RTL
=========================

Name: regfile_wb_responder

Overview:
- 32 x 64-bit RISC-V integer register file.
- Acts as the responder to the write-back stage's register-write interface and returns the completion handshake that stage waits on before asserting its done flag.
- Provides two read ports for decode.
- Keeps a per-register busy scoreboard, set by decode and cleared by write-back commits.

Parameters:
- XLEN, 64, register data width.
- NREGS, 32, number of architectural registers; the address width is log2(NREGS).

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous active-high reset
- wb_module_enable  input  1  write-back stage active for the current instruction
- register_write_enable  input  1  write request from write-back
- register_write_addr  input  5  destination register
- register_write_data  input  XLEN  write data
- wb_write_complete  output  1  completion handshake to write-back
- read_addr1  input  5  rs1 address
- read_addr2  input  5  rs2 address
- read_data1  output  XLEN  rs1 data
- read_data2  output  XLEN  rs2 data
- mark_busy_valid  input  1  decode claims a destination register
- mark_busy_addr  input  5  claimed register
- rs1_busy  output  1  busy bit for read_addr1
- rs2_busy  output  1  busy bit for read_addr2

Behaviour:
- Clock and reset: single clock. Reset is asynchronous and active-high.
- Reset values:
  - all 32 registers = 0
  - all busy bits = 0
  - FSM = IDLE
  - wb_write_complete = 0
- Read ports:
  - Combinational from the array.
  - Address 0 always reads 0 and is never busy.
- Write FSM, two states:
  - IDLE:
    - wb_write_complete = 0.
    - When wb_module_enable = 1 at a rising edge, move to DONE.
    - On that same edge, if register_write_enable = 1 and register_write_addr != 0, write register_write_data to register_write_addr.
    - If register_write_enable = 0 (store, branch, fence, system instructions), still move to DONE so write-back can finish.
  - DONE:
    - wb_write_complete = 1, registered; it asserts in the cycle after the request edge.
    - All write requests are ignored. The write-back stage drops register_write_enable while complete is high, and no duplicate write may occur.
    - Stay in DONE while wb_module_enable = 1.
    - When wb_module_enable = 0 at an edge, return to IDLE; complete falls the following cycle.
- Handshake latency: one cycle from the accepted request to wb_write_complete.
- Back-to-back instructions:
  - wb_module_enable must drop for at least one cycle between instructions.
  - If it stays high, the block remains in DONE and does not accept a second write.
- Scoreboard:
  - A set occurs when mark_busy_valid = 1 and mark_busy_addr != 0.
  - A clear occurs on the IDLE->DONE commit edge when register_write_enable = 1, for register_write_addr.
  - If a set and a clear target the same register on the same edge, set wins (a newer producer now owns the register).
  - If they target different registers, both take effect.
- Writes to x0: the array is not modified and the scoreboard is not changed, but the handshake still completes.
- Reset mid-operation: FSM returns to IDLE and complete drops immediately (asynchronous). Array and busy bits are cleared.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined:
  - While the FSM is in IDLE with wb_module_enable = 1, register_write_enable = 1 and register_write_addr != 0, a read port whose address matches register_write_addr returns register_write_data combinationally.
  - The matching rsN_busy reads 0 in that cycle.
- Undefined:
  - Reads return the array value; new data is visible only from the cycle after the write edge.
  - Busy clears on the edge, not before.

Test Plan:
- Reset is asserted mid-DONE → wb_write_complete drops without waiting for a clock; reads of x1..x31 return 0; rs1_busy = rs2_busy = 0.
- wb_module_enable = 1, register_write_enable = 1, addr = 5, data = 0xDEAD_BEEF_0000_1234 → complete = 1 one cycle later. While wb_module_enable stays high, complete holds, and a changed data value 0x1 on the write port does not overwrite x5. After wb_module_enable drops, complete falls one cycle later and read_addr1 = 5 returns 0xDEAD_BEEF_0000_1234.
- Store-like instruction: wb_module_enable = 1, register_write_enable = 0 → complete = 1 after one cycle; no register changes.
- Write to x0 with data 0xFFFF_FFFF_FFFF_FFFF → handshake completes; x0 still reads 0.
- mark_busy on x7 → rs1_busy = 1 for read_addr1 = 7. A commit to x7 clears it. On a later edge, mark_busy x7 together with a commit to x7 leaves busy = 1. mark_busy x3 together with a commit to x9 leaves x3 busy and x9 not busy.
- With REGFILE_BYPASS_EN: in the request cycle for addr 12, data 0x55, read_addr2 = 12 returns 0x55 and rs2_busy = 0. Without the macro, the same cycle returns the old value.

Source files
------------

// File: rtl/regfile_wb_responder.sv
// regfile_wb_responder
//
// Purpose:
//   32 x 64-bit RISC-V integer register file. It acts as the responder to
//   the write-back stage's register-write interface and returns the
//   completion handshake that write-back waits on. It provides two
//   combinational read ports for decode. It also keeps a per-register busy
//   scoreboard: decode sets a bit, and write-back commits clear it.
//
// Optional feature (macro REGFILE_BYPASS_EN):
//   When the macro is defined, a write that is being committed in the
//   current cycle is forwarded to any read port with a matching address.
//   The matching busy flag also reads 0 in that cycle. When the macro is
//   undefined, reads see new data and cleared busy bits only after the
//   commit edge.
//
// Ports:
//   clk                   in   clock
//   reset                 in   asynchronous active-high reset
//   wb_module_enable      in   write-back stage active for this instruction
//   register_write_enable in   write request from write-back
//   register_write_addr   in   destination register
//   register_write_data   in   write data
//   wb_write_complete     out  registered completion handshake
//   read_addr1/2          in   rs1/rs2 addresses
//   read_data1/2          out  rs1/rs2 data (x0 reads 0)
//   mark_busy_valid       in   decode claims a destination register
//   mark_busy_addr        in   claimed register
//   rs1_busy/rs2_busy     out  scoreboard bits for read_addr1/2

module regfile_wb_responder #(
    parameter  int XLEN  = 64,
    parameter  int NREGS = 32,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            wb_module_enable,
    input  logic            register_write_enable,
    input  logic [AW-1:0]   register_write_addr,
    input  logic [XLEN-1:0] register_write_data,
    output logic            wb_write_complete,
    input  logic [AW-1:0]   read_addr1,
    input  logic [AW-1:0]   read_addr2,
    output logic [XLEN-1:0] read_data1,
    output logic [XLEN-1:0] read_data2,
    input  logic            mark_busy_valid,
    input  logic [AW-1:0]   mark_busy_addr,
    output logic            rs1_busy,
    output logic            rs2_busy
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        DONE = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [XLEN-1:0]   regs_q [NREGS];
    logic [NREGS-1:0]  busy_q, busy_d;

    // The one and only write for an instruction happens on the IDLE->DONE
    // edge. While in DONE, every write request is ignored.
    logic commit;
    logic wr_en;
    logic busy_set;

    assign commit   = (state_q == IDLE) && wb_module_enable;
    assign wr_en    = commit && register_write_enable && (register_write_addr != '0);
    assign busy_set = mark_busy_valid && (mark_busy_addr != '0);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (wb_module_enable)  state_d = DONE;
            DONE: if (!wb_module_enable) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // The set is applied after the clear. If both hit the same register,
    // the newer producer keeps it busy.
    always_comb begin
        busy_d = busy_q;
        if (wr_en)    busy_d[register_write_addr] = 1'b0;
        if (busy_set) busy_d[mark_busy_addr]      = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            busy_q  <= '0;
            for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            if (wr_en) regs_q[register_write_addr] <= register_write_data;
        end
    end

    // Complete comes straight from the state register. It is therefore
    // glitch-free, and it drops at once when reset is asserted.
    assign wb_write_complete = (state_q == DONE);

    always_comb begin
        read_data1 = '0;
        read_data2 = '0;
        rs1_busy   = 1'b0;
        rs2_busy   = 1'b0;
        if (read_addr1 != '0) begin
            read_data1 = regs_q[read_addr1];
            rs1_busy   = busy_q[read_addr1];
        end
        if (read_addr2 != '0) begin
            read_data2 = regs_q[read_addr2];
            rs2_busy   = busy_q[read_addr2];
        end
`ifdef REGFILE_BYPASS_EN
        // Forward the value being committed this cycle (wr_en already
        // excludes x0).
        if (wr_en && (read_addr1 == register_write_addr)) begin
            read_data1 = register_write_data;
            rs1_busy   = 1'b0;
        end
        if (wr_en && (read_addr2 == register_write_addr)) begin
            read_data2 = register_write_data;
            rs2_busy   = 1'b0;
        end
`endif
    end

endmodule
